// File: rtl/vga_sync_receiver.sv
// ---------------------------------------------------------------------------
// vga_sync_receiver
//
// Locks onto an incoming VGA timing stream (active-low hsync/vsync plus 4:4:4
// RGB) clocked by the pixel clock. It checks line and frame lengths against
// the expected timing and emits active-area pixels with their coordinates.
//
// Pipeline:
//   stage 1 : hsync, vsync and RGB registered from the pins. All edge
//             detection, counting and error checks run on these values.
//   stage 2 : registered outputs. The pin-to-pix_* latency is 2 dclk.
//
// Coordinate alignment: the stage-1 pixel that carries an hsync falling edge
// is column 0, and the pixel that carries a vsync falling edge is line 0. The
// window test therefore uses the next-state counters (hc_d, vc_d), which are
// the coordinates of the pixel currently held in stage 1.
//
// Ports:
//   dclk            pixel clock; the only clock
//   clr_n           asynchronous active-low reset
//   hsync, vsync    active-low sync from the source
//   red/green/blue  4-bit pixel colour
//   locked          timing lock (state == LOCKED)
//   pix_valid       pix_* hold an active-area pixel
//   pix_x, pix_y    active-area coordinate (hc-HBP, vc-VBP)
//   pix_red/green/blue  captured colour
//   frame_start     1-cycle pulse at each vsync falling edge while locked
//   sync_err        1-cycle pulse on a timing violation (ALIGN/LOCKED only)
//   err_count       saturating count of sync_err pulses
//
// Optional feature, macro VGA_RX_CHECKSUM_EN:
//   frame_sum       mod-2^16 sum of {r,g,b} over the valid pixels of a frame
//   frame_sum_valid pulses with frame_start when frame_sum is updated
// ---------------------------------------------------------------------------
module vga_sync_receiver #(
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HBP     = 310,
  parameter int HFP     = 790,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic        dclk,
  input  logic        clr_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [3:0]  pix_red,
  output logic [3:0]  pix_green,
  output logic [3:0]  pix_blue,
  output logic        frame_start,
  output logic        sync_err,
  output logic [7:0]  err_count
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        frame_sum_valid
`endif
);

  // 10-bit copies of the timing parameters keep every compare width-matched.
  localparam logic [9:0] HLAST = 10'(HPIXELS - 1);
  localparam logic [9:0] HTOUT = 10'(HPIXELS);
  localparam logic [9:0] VLAST = 10'(VLINES - 1);
  localparam logic [9:0] HBP_W = 10'(HBP);
  localparam logic [9:0] HFP_W = 10'(HFP);
  localparam logic [9:0] VBP_W = 10'(VBP);
  localparam logic [9:0] VFP_W = 10'(VFP);
  localparam logic [9:0] CMAX  = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // ---------------------------------------------------------------- stage 1
  logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [11:0] rgb_q;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      rgb_q     <= {red, green, blue};
    end
  end

  logic hs_fall, vs_fall;
  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;

  // --------------------------------------------------------------- counters
  logic [9:0] hc_q, hc_d, vc_q, vc_d;

  always_comb begin
    hc_d = (hc_q == CMAX) ? hc_q : hc_q + 10'd1;
    if (hs_fall) hc_d = '0;
    vc_d = vc_q;
    if (hs_fall && vc_q != CMAX) vc_d = vc_q + 10'd1;
    if (vs_fall) vc_d = '0;            // vsync edge wins over the line step
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ------------------------------------------------------------ error checks
  // A line ends early/late when the edge arrives with the wrong count; a
  // missing edge is flagged once, on the cycle the count reaches HPIXELS.
  logic line_err, frame_err, err_seen;
  assign line_err  = hs_fall ? (hc_q != HLAST) : (hc_q == HTOUT);
  assign frame_err = vs_fall && (vc_q != VLAST);

  // ------------------------------------------------------------------- FSM
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vs_fall) state_d = ALIGN;
      ALIGN:   if (line_err || frame_err) state_d = SEARCH;
               else if (vs_fall)          state_d = LOCKED;
      LOCKED:  if (line_err || frame_err) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  assign err_seen = (line_err || frame_err) && (state_q != SEARCH);

  // frame_start only for edges seen in LOCKED that keep the lock; the edge
  // that completes ALIGN -> LOCKED is not a frame start.
  logic fs_d;
  assign fs_d = vs_fall && (state_q == LOCKED) && (state_d == LOCKED);

  logic       locked_q, sync_err_q, frame_start_q;
  logic [7:0] err_count_q;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= SEARCH;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      locked_q      <= (state_d == LOCKED);
      sync_err_q    <= err_seen;
      frame_start_q <= fs_d;
      if (err_seen && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic in_win, pix_en;
  assign in_win = (hc_d >= HBP_W) && (hc_d < HFP_W) &&
                  (vc_d >= VBP_W) && (vc_d < VFP_W);
  assign pix_en = (state_d == LOCKED) && in_win;

  logic        pix_valid_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [11:0] pix_rgb_q;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
    end else begin
      pix_valid_q <= pix_en;
      // Outside the window the last pixel is held.
      if (pix_en) begin
        pix_x_q   <= hc_d - HBP_W;
        pix_y_q   <= vc_d - VBP_W;
        pix_rgb_q <= rgb_q;
      end
    end
  end

  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;
  assign frame_start = frame_start_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_red     = pix_rgb_q[11:8];
  assign pix_green   = pix_rgb_q[7:4];
  assign pix_blue    = pix_rgb_q[3:0];

`ifdef VGA_RX_CHECKSUM_EN
  // -------------------------------------------------------- frame checksum
  logic [15:0] acc_q, acc_d, acc_add, sum_q;
  logic        sum_vld_q;

  assign acc_add = pix_en ? {4'h0, rgb_q} : 16'h0000;

  always_comb begin
    acc_d = acc_q + acc_add;
    if (vs_fall) acc_d = '0;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      acc_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sum_vld_q <= fs_d;
      if (fs_d) sum_q <= acc_q + acc_add;
    end
  end

  assign frame_sum       = sum_q;
  assign frame_sum_valid = sum_vld_q;
`endif

endmodule
